// File: rtl/aoi_pipe_unit.sv
// Two-stage pipelined four-operand bitwise logic unit with valid/ready handshake,
// per-result popcount and a wrapping count of delivered results.
module aoi_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int PC_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [PC_W-1:0]  out_ones,
  output logic [CNT_W-1:0] out_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] func_y;
  logic [PC_W-1:0]  s1_ones;
  logic             s2_adv;
  logic             s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    func_y = '0;
    unique case (in_mode)
      2'd0: func_y = (in_a & in_b) | (in_c | in_d);
      2'd1: func_y = (in_a | in_b) & (in_c | in_d);
      2'd2: func_y = (in_a & in_b) | (in_c & in_d);
      2'd3: func_y = in_a ^ in_b ^ in_c ^ in_d;
      default: func_y = '0;
    endcase
  end

  // Popcount is computed from the S1 register so it lands in S2 alongside the result.
  always_comb begin
    s1_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_ones = s1_ones + PC_W'(s1_y[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_y <= func_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ones  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y    <= s1_y;
        out_ones <= s1_ones;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aoi_pipe_unit.sv
// Scoreboard bench for aoi_pipe_unit: directed operand sets push expected results,
// a monitor pops and compares on every delivered result.
module tb_aoi_pipe_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int PC_W  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic [PC_W-1:0]  out_ones;
  logic [CNT_W-1:0] out_cnt;

  typedef struct {
    logic [WIDTH-1:0] y;
    int               ones;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  aoi_pipe_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ones(out_ones), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_y), 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_ones", 32'(out_ones), 32'(e.ones));
        chk("out_cnt", 32'(out_cnt), 32'(exp_cnt));
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  // Offer one set for a single cycle; starts and ends just after a rising edge.
  task automatic offer(input logic [7:0] a, b, c, d, input logic [1:0] m,
                       input logic [7:0] ey, input int eo, output bit acc);
    exp_t e;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c; in_d = d; in_mode = m;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      e.y = ey;
      e.ones = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode = 2'd0;
  endtask

  task automatic send(input logic [7:0] a, b, c, d, input logic [1:0] m,
                      input logic [7:0] ey, input int eo);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      offer(a, b, c, d, m, ey, eo, acc);
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_ones", 32'(out_ones), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single set with latency check.
    out_ready = 1'b1;
    send(8'hF0, 8'h3C, 8'h01, 8'h02, 2'd0, 8'h33, 4);
    @(negedge clk);
    chk("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_y", 32'(out_y), 32'h33);
    drain();
    chk("cnt_after_first", 32'(out_cnt), 32'd1);

    // All four modes back to back.
    send(8'hAA, 8'hCC, 8'hF0, 8'h0F, 2'd0, 8'hFF, 8);
    send(8'hAA, 8'hCC, 8'hF0, 8'h0F, 2'd1, 8'hEE, 6);
    send(8'hAA, 8'hCC, 8'hF0, 8'h0F, 2'd2, 8'h88, 2);
    send(8'hAA, 8'hCC, 8'hF0, 8'h0F, 2'd3, 8'h99, 4);
    drain();
    chk("cnt_after_modes", 32'(out_cnt), 32'd5);

    // Backpressure: two sets fill the pipe, the third is refused.
    out_ready = 1'b0;
    offer(8'hF0, 8'h3C, 8'h01, 8'h02, 2'd0, 8'h33, 4, acc);
    chk("bp_accept1", 32'(acc), 32'd1);
    offer(8'h0F, 8'hF0, 8'h00, 8'h01, 2'd1, 8'h01, 1, acc);
    chk("bp_accept2", 32'(acc), 32'd1);
    offer(8'h12, 8'h34, 8'h00, 8'h00, 2'd3, 8'h26, 3, acc);
    chk("bp_refuse3", 32'(acc), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_y", 32'(out_y), 32'h33);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h12, 8'h34, 8'h00, 8'h00, 2'd3, 8'h26, 3);
    drain();
    chk("cnt_after_bp", 32'(out_cnt), 32'd8);

    // Popcount extremes.
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd3, 8'h00, 0);
    send(8'hFF, 8'h00, 8'h00, 8'h00, 2'd3, 8'hFF, 8);
    drain();

    // Counter wrap: 17 more results through a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      logic [7:0] v;
      v = 8'(i * 37 + 5);
      send(v, 8'hFF, 8'h00, 8'h00, 2'd2, v, $countones(v));
    end
    drain();
    chk("cnt_wrapped", 32'(out_cnt), 32'd11);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(8'h01, 8'h01, 8'h00, 8'h00, 2'd2, 8'h01, 1);
    send(8'h03, 8'h03, 8'h00, 8'h00, 2'd2, 8'h03, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_cnt", 32'(out_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst2", 32'(in_ready), 32'd1);
    chk("no_ghost_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'hF0, 8'h3C, 8'h01, 8'h02, 2'd0, 8'h33, 4);
    drain();
    chk("cnt_after_rst", 32'(out_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
